// File: rtl/diff_array_pipe.sv
// diff_array_pipe
//   Per-lane difference of two sample rows (ORG - CUR) with optional absolute
//   value, plus a running sum of absolute differences (SAD) across a block of
//   ROWS rows. One output register stage with valid/ready handshaking. The
//   output holds under backpressure. A new row can load in the same cycle
//   that the previous row is taken, so there is no bubble.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input row handshake (in_ready is combinational)
//   ORG, CUR            packed unsigned sample rows, lane i at [i*WIDTH +: WIDTH]
//   abs_mode            0: signed diff, 1: absolute diff (sampled with the row)
//   clr                 synchronous block restart
//   out_valid, out_ready output handshake
//   diff                packed two's-complement lane results, lane i at [i*(WIDTH+1) +: WIDTH+1]
//   row_idx             row number of the output row within its block
//   out_last            output row is the last row of its block
//   sad                 running |diff| sum over the block, through the output row
module diff_array_pipe #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NUM_INPUTS = 8,
   parameter int unsigned ROWS       = 8,
   localparam int unsigned SAD_RAW   = WIDTH + $clog2(NUM_INPUTS * ROWS),
   localparam int unsigned SADW      = (SAD_RAW > WIDTH + 1) ? SAD_RAW : WIDTH + 1,
   localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned DW        = WIDTH + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH*NUM_INPUTS-1:0] ORG,
   input  logic [WIDTH*NUM_INPUTS-1:0] CUR,
   input  logic                       abs_mode,
   input  logic                       clr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_INPUTS*DW-1:0]   diff,
   output logic [RW-1:0]              row_idx,
   output logic                       out_last,
   output logic [SADW-1:0]            sad
);

   localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);

   logic                     valid_q, valid_d;
   logic [NUM_INPUTS*DW-1:0] diff_q, diff_d;
   logic [RW-1:0]            idx_q, idx_d;
   logic                     last_q, last_d;
   logic [SADW-1:0]          sad_q, sad_d;
   logic [RW-1:0]            cnt_q, cnt_d;

   logic                     accept;
   logic [RW-1:0]            base_row;
   logic [NUM_INPUTS*DW-1:0] diff_row;
   logic [SADW-1:0]          row_sad;
   logic [DW-1:0]            lane_d;
   logic [DW-1:0]            lane_abs;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // clr makes the row accepted in the same cycle row 0 of a fresh block.
   assign base_row = clr ? '0 : cnt_q;

   // Lane arithmetic: zero-extend to WIDTH+1 so the difference never wraps.
   always_comb begin
      row_sad  = '0;
      diff_row = '0;
      lane_d   = '0;
      lane_abs = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         lane_d   = {1'b0, ORG[i*WIDTH +: WIDTH]} - {1'b0, CUR[i*WIDTH +: WIDTH]};
         lane_abs = lane_d[WIDTH] ? (DW'(0) - lane_d) : lane_d;
         diff_row[i*DW +: DW] = abs_mode ? lane_abs : lane_d;
         row_sad  = row_sad + SADW'(lane_abs);
      end
   end

   always_comb begin
      valid_d = valid_q;
      diff_d  = diff_q;
      idx_d   = idx_q;
      last_d  = last_q;
      sad_d   = sad_q;
      cnt_d   = clr ? '0 : cnt_q;
      if (accept) begin
         valid_d = 1'b1;
         diff_d  = diff_row;
         idx_d   = base_row;
         last_d  = (base_row == LastRow);
         sad_d   = (base_row == '0) ? row_sad : (sad_q + row_sad);
         cnt_d   = (base_row == LastRow) ? '0 : (base_row + 1'b1);
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         diff_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         sad_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         diff_q  <= diff_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         sad_q   <= sad_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign diff      = diff_q;
   assign row_idx   = idx_q;
   assign out_last  = last_q;
   assign sad       = sad_q;

endmodule

// File: doc/diff_array_pipe.md
DIFF_ARRAY_PIPE -- requirements
Module: diff_array_pipe

Interface
REQ-001 Parameter WIDTH, default 8: unsigned sample width per lane.
REQ-002 Parameter NUM_INPUTS, default 8: number of lanes per row; 1 or greater.
REQ-003 Parameter ROWS, default 8: rows per block; 1 or greater.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 in_valid  in  1  ORG/CUR/abs_mode valid.
REQ-007 in_ready  out  1  block accepts a row this cycle.
REQ-008 ORG  in  WIDTH*NUM_INPUTS  original samples, unsigned; lane i at [(i+1)*WIDTH-1 : i*WIDTH].
REQ-009 CUR  in  WIDTH*NUM_INPUTS  current/prediction samples, same packing.
REQ-010 abs_mode  in  1  0 = signed difference, 1 = absolute difference; sampled with the row.
REQ-011 clr  in  1  synchronous block restart.
REQ-012 out_valid  out  1  diff/sad/row_idx/out_last valid.
REQ-013 out_ready  in  1  downstream accepts output.
REQ-014 diff  out  NUM_INPUTS*(WIDTH+1)  per-lane result, two's complement; lane i at [(i+1)*(WIDTH+1)-1 : i*(WIDTH+1)].
REQ-015 row_idx  out  max(1,clog2(ROWS))  row number of the output row within its block.
REQ-016 out_last  out  1  output row is row ROWS-1.
REQ-017 sad  out  SADW = WIDTH+clog2(NUM_INPUTS*ROWS) (minimum WIDTH+1)  running sum of |diff| over the block, through the output row.

Function
REQ-018 Input acceptance: accept occurs when in_valid && in_ready; in_ready = !out_valid || out_ready; in_ready is combinational.
REQ-019 Output register: a single output register stage; latency from accept to out_valid is exactly 1 cycle.
REQ-020 Output hold: while out_valid && !out_ready, diff, row_idx, out_last and sad stay stable, and no accept occurs.
REQ-021 Simultaneous output and input: when out_valid && out_ready && in_valid in one cycle, the register loads the new row and out_valid stays 1; there is no bubble, loss or duplication.
REQ-022 Drain: when out_ready && !accept, out_valid goes to 0 next cycle.
REQ-023 Lane arithmetic: d_i = ORG_i - CUR_i, computed at WIDTH+1 bits signed; range -(2^WIDTH-1) .. 2^WIDTH-1.
REQ-024 Lane output: diff lane i = d_i when abs_mode=0; diff lane i = |d_i| (non-negative, WIDTH+1 bits) when abs_mode=1.
REQ-025 Row SAD: row_sad = sum of |d_i| over all lanes, independent of abs_mode.
REQ-026 Row counter: an internal counter holds the row number of the next accepted row; it increments on accept and wraps from ROWS-1 to 0; with ROWS=1 it stays 0.
REQ-027 Row outputs on accept: row_idx is loaded with the counter value; out_last = (counter == ROWS-1).
REQ-028 SAD on accept: sad loads row_sad when the counter is 0, otherwise sad + row_sad; sad never overflows at SADW.
REQ-029 clr: clr=1 sets the counter to 0 for the next cycle and forces the accumulation base to 0.
REQ-030 clr with accept: if clr coincides with an accept, the accepted row is treated as row 0 (row_idx=0, sad=row_sad), and the counter becomes 1 (0 when ROWS=1).
REQ-031 clr and the output register: clr does not alter the output register or out_valid.
REQ-032 Don't-care inputs: ORG/CUR/abs_mode are ignored when no accept occurs.

Reset
REQ-033 While rst_n=0: out_valid=0, diff=0, row_idx=0, out_last=0, sad=0, counter=0, all taking effect immediately without waiting for clk.
REQ-034 in_ready is 1 during reset because out_valid=0.
REQ-035 First row accepted after reset release is row 0.
REQ-036 Reset mid-block discards the partial block; no output is produced for rows in flight.

Verification (WIDTH=8, NUM_INPUTS=8, ROWS=4)
REQ-037 Sign/abs: lane0 ORG=0, CUR=255, abs_mode=0 -> diff lane0=9'h101 (-255); repeat with abs_mode=1 -> 9'h0FF, row_sad contribution 255.
REQ-038 Backpressure: out_ready=0 for 3 cycles with in_valid=1 and 3 distinct rows -> in_ready=0 after the first row, output stable, then out_ready=1 -> rows emerge in order, each exactly once, back-to-back.
REQ-039 Block accumulation: 4 rows, all lanes ORG=10, CUR=3 -> row_idx 0,1,2,3, sad 56,112,168,224, out_last only on row 3; 5th row -> row_idx=0, sad=56.
REQ-040 clr: clr pulsed after 2 rows, together with the 3rd row's accept -> that row has row_idx=0, sad=56; next row has row_idx=1, sad=112.
REQ-041 Reset mid-operation: rst_n low asynchronously while out_valid=1 and row_idx=2 -> out_valid, sad and row_idx are 0 before the next edge; first row after release has row_idx=0.
REQ-042 Extremes: all lanes ORG=255, CUR=0, 4 rows -> row 3 has out_last=1, sad=8160 (13-bit), no wrap; all lanes ORG=0, CUR=255, abs_mode=0 -> every diff lane = -255, sad=8160.
